// File: rtl/fifo_drain_ctrl_pkg.sv
// Shared defaults, widths and FSM encoding for the FIFO drain controller.
package fifo_drain_ctrl_pkg;

  localparam int unsigned WIDTH_DEF     = 32;
  localparam int unsigned RD_LAT_DEF    = 2;
  localparam int unsigned BUF_DEPTH_DEF = 4;
  localparam int unsigned LEN_W         = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Width of a counter that must hold 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/drain_obuf.sv
// Output buffer: DEPTH x WIDTH register file with push/pop and occupancy count.
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   push, wdata   write a word at the tail
//   pop           retire the head word (ignored when empty)
//   head          current head word
//   count         number of stored words
module drain_obuf
  import fifo_drain_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DEPTH = BUF_DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic [WIDTH-1:0]            wdata,
  input  logic                        pop,
  output logic [WIDTH-1:0]            head,
  output logic [cnt_width(DEPTH)-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q;
  logic [PTR_W-1:0] rptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_pop;

  assign do_pop = pop && (cnt_q != '0);

  // Storage, pointers (natural power-of-two wrap) and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= wdata;
        wptr_q        <= wptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rptr_q <= rptr_q + PTR_W'(1);
      end
      case ({push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head  = mem_q[rptr_q];
  assign count = cnt_q;

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Drains len words from an async FIFO read port into a small credit-managed
// output buffer and hands them downstream over a valid/ready interface.
// Ports:
//   clk, rst_n            read-side clock, synchronous active-low reset
//   start, len            begin a transfer of len words (taken in IDLE only)
//   abort                 stop issuing pops (RUN only)
//   rinc, rempty, rdata   FIFO read port; rdata valid RD_LAT edges after a pop
//   out_valid/ready/data  downstream word handshake
//   busy, done            activity flag and one-cycle end-of-transfer pulse
//   words_out             words delivered in the current or last transfer
module fifo_drain_ctrl
  import fifo_drain_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH     = WIDTH_DEF,
  parameter int unsigned RD_LAT    = RD_LAT_DEF,
  parameter int unsigned BUF_DEPTH = BUF_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  output logic             rinc,
  input  logic             rempty,
  input  logic [WIDTH-1:0] rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] words_out
);

  localparam int unsigned CNT_W = cnt_width(BUF_DEPTH);
  localparam int unsigned SUM_W = CNT_W + 1;

  state_t             state_q;
  state_t             state_d;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   issued_q;
  logic [LEN_W-1:0]   words_q;
  logic [RD_LAT-1:0]  pipe_q;
  logic [CNT_W-1:0]   inflight_q;
  logic [CNT_W-1:0]   buf_cnt;
  logic               load;
  logic               accept;
  logic               push;
  logic               pop;
  logic               credit_ok;

  // Words already popped but not yet delivered must fit in the buffer.
  assign credit_ok = ({1'b0, inflight_q} + {1'b0, buf_cnt}) < SUM_W'(BUF_DEPTH);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and FSM-decoded outputs.
  always_comb begin
    state_d = state_q;
    rinc    = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          load    = 1'b1;
          state_d = (len == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        rinc = (issued_q < len_q) && !abort && credit_ok;
        if ((issued_q == len_q) || abort) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if ((inflight_q == '0) && (buf_cnt == '0)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign accept    = rinc && !rempty;
  assign push      = pipe_q[RD_LAT-1];
  assign out_valid = (buf_cnt != '0);
  assign pop       = out_valid && out_ready;

  // In-flight pipe: one valid bit per accepted pop, aligned to rdata arrival.
  if (RD_LAT > 1) begin : g_pipe
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        pipe_q <= '0;
      end else begin
        pipe_q <= {pipe_q[RD_LAT-2:0], accept};
      end
    end
  end else begin : g_pipe1
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        pipe_q <= '0;
      end else begin
        pipe_q <= accept;
      end
    end
  end

  // Transfer length, issue/delivery counters and in-flight occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_q      <= '0;
      issued_q   <= '0;
      words_q    <= '0;
      inflight_q <= '0;
    end else begin
      if (load) begin
        len_q    <= len;
        issued_q <= '0;
        words_q  <= '0;
      end else begin
        if (accept) begin
          issued_q <= issued_q + LEN_W'(1);
        end
        if (pop) begin
          words_q <= words_q + LEN_W'(1);
        end
      end
      inflight_q <= inflight_q + CNT_W'(accept) - CNT_W'(push);
    end
  end

  drain_obuf #(
    .WIDTH (WIDTH),
    .DEPTH (BUF_DEPTH)
  ) u_obuf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (rdata),
    .pop   (pop),
    .head  (out_data),
    .count (buf_cnt)
  );

  assign words_out = words_q;

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Bench for fifo_drain_ctrl: a FIFO with read latency, a word-level
// scoreboard and a credit model driven by directed and random transfers.
module tb_fifo_drain_ctrl;
  import fifo_drain_ctrl_pkg::*;

  localparam int unsigned WIDTH     = WIDTH_DEF;
  localparam int unsigned RD_LAT    = RD_LAT_DEF;
  localparam int unsigned BUF_DEPTH = BUF_DEPTH_DEF;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [7:0]       len;
  logic             abort;
  logic             rinc;
  logic             rempty;
  logic [WIDTH-1:0] rdata;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;
  logic             done;
  logic [7:0]       words_out;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic [WIDTH-1:0] fifo_q[$];
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] got_q[$];
  logic [WIDTH-1:0] dl_d[RD_LAT];
  bit               dl_v[RD_LAT];
  int               issued    = 0;
  int               delivered = 0;
  int               len_m     = 0;
  bit               run_phase = 1'b0;
  bit               force_empty = 1'b0;

  fifo_drain_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .abort     (abort),
    .rinc      (rinc),
    .rempty    (rempty),
    .rdata     (rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done),
    .words_out (words_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    rdata  = dl_v[RD_LAT-1] ? dl_d[RD_LAT-1] : WIDTH'($urandom);
    rempty = (fifo_q.size() == 0) || force_empty;
  endtask

  task automatic preload(input int n, input bit ramp, input logic [WIDTH-1:0] base);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(ramp ? base + WIDTH'(i) : WIDTH'($urandom));
    end
    drive_fifo();
  endtask

  // Advance one clock, updating the model from what the DUT saw at the edge.
  task automatic tick();
    bit               acc;
    bit               opop;
    bit               arr;
    bit               ab;
    bit               st;
    bit               rst;
    int               ln;
    logic [WIDTH-1:0] od;
    acc  = (rinc === 1'b1) && (rempty === 1'b0);
    opop = (out_valid === 1'b1) && (out_ready === 1'b1);
    od   = out_data;
    arr  = dl_v[RD_LAT-1];
    ab   = abort;
    st   = start;
    rst  = !rst_n;
    ln   = int'(len);
    @(posedge clk);
    #1;
    if (rst) begin
      fifo_q.delete();
      exp_q.delete();
      for (int k = 0; k < int'(RD_LAT); k++) dl_v[k] = 1'b0;
      issued    = 0;
      delivered = 0;
      len_m     = 0;
      run_phase = 1'b0;
    end else begin
      if (opop && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        delivered++;
        got_q.push_back(od);
      end
      if (arr) exp_q.push_back(dl_d[RD_LAT-1]);
      for (int k = int'(RD_LAT) - 1; k > 0; k--) begin
        dl_d[k] = dl_d[k-1];
        dl_v[k] = dl_v[k-1];
      end
      dl_v[0] = acc;
      dl_d[0] = '0;
      if (acc) begin
        if (fifo_q.size() != 0) dl_d[0] = fifo_q.pop_front();
        issued++;
      end
      if (ab) run_phase = 1'b0;
      if (st) begin
        len_m     = ln;
        issued    = 0;
        delivered = 0;
        run_phase = (ln != 0);
        got_q.delete();
      end
    end
    drive_fifo();
  endtask

  // Per-cycle comparison against the model once inputs for the cycle are set.
  task automatic cycle_check();
    bit exp_rinc;
    bit complete;
    #1;
    exp_rinc = run_phase && !abort && (issued < len_m) &&
               ((issued - delivered) < int'(BUF_DEPTH));
    chk("rinc", 32'(rinc), 32'(exp_rinc));
    chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) chk("out_data", 32'(out_data), 32'(exp_q[0]));
    chk("words_out", 32'(words_out), 32'(delivered));
    complete = (issued == delivered) && !(run_phase && (issued < len_m));
    if (done === 1'b1) chk("done_complete", 32'(complete), 32'd1);
  endtask

  // emp_mode: 0 never stall, 1 random stall, 2 toggle every 3 cycles.
  task automatic run_xfer(input int n, input int rdy_pct, input int hold,
                          input int emp_mode, input int abort_at,
                          output int done_cyc);
    int cyc = 0;
    bit seen = 1'b0;
    int exp_words;
    done_cyc  = -1;
    start     = 1'b1;
    len       = 8'(n);
    abort     = 1'b0;
    out_ready = 1'b0;
    tick();
    start = 1'b0;
    #1;
    chk("busy_after_start", 32'(busy), 32'd1);
    while (!seen && cyc < 3000) begin
      out_ready = (cyc >= hold) && ($urandom_range(99) < rdy_pct);
      case (emp_mode)
        1:       force_empty = ($urandom_range(99) < 30);
        2:       force_empty = ((cyc / 3) % 2) == 1;
        default: force_empty = 1'b0;
      endcase
      abort = (abort_at >= 0) && (issued >= abort_at);
      drive_fifo();
      cycle_check();
      if (hold > 0 && cyc == hold - 1) begin
        chk("credit_stall_pops", 32'(issued), 32'(BUF_DEPTH));
        chk("credit_stall_valid", 32'(out_valid), 32'd1);
      end
      if (done === 1'b1) begin
        seen     = 1'b1;
        done_cyc = cyc;
        chk("busy_in_done", 32'(busy), 32'd1);
      end
      tick();
      cyc++;
    end
    chk("done_seen", 32'(seen), 32'd1);
    abort       = 1'b0;
    out_ready   = 1'b0;
    force_empty = 1'b0;
    drive_fifo();
    #1;
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("done_single", 32'(done), 32'd0);
    exp_words = (abort_at >= 0 && abort_at < n) ? abort_at : n;
    chk("words_final", 32'(words_out), 32'(exp_words));
  endtask

  initial begin
    int dc;
    int n;
    int ab;
    for (int k = 0; k < int'(RD_LAT); k++) begin
      dl_v[k] = 1'b0;
      dl_d[k] = '0;
    end
    rst_n = 1'b0; start = 1'b0; len = '0; abort = 1'b0; out_ready = 1'b0;
    drive_fifo();
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_rinc", 32'(rinc), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_words_out", 32'(words_out), 32'd0);

    // Ordered ramp, downstream always ready.
    preload(10, 1'b1, WIDTH'(32'h100));
    run_xfer(10, 100, 0, 0, -1, dc);
    chk("ramp_count", 32'(got_q.size()), 32'd10);
    for (int i = 0; i < 10 && i < got_q.size(); i++) begin
      chk("ramp_order", 32'(got_q[i]), 32'h100 + 32'(i));
    end

    // Downstream stalled for 20 cycles: credit limits pops to the buffer depth.
    preload(10, 1'b0, '0);
    run_xfer(10, 100, 20, 0, -1, dc);

    // FIFO empty toggling every 3 cycles.
    preload(6, 1'b0, '0);
    run_xfer(6, 70, 0, 2, -1, dc);

    // Abort once 3 pops have been accepted.
    preload(20, 1'b0, '0);
    run_xfer(20, 100, 0, 0, 3, dc);
    chk("abort_words", 32'(words_out), 32'd3);

    // Zero-length transfer: done in the first cycle after start.
    run_xfer(0, 100, 0, 0, -1, dc);
    chk("len0_done_cycle", 32'(dc), 32'd0);

    // Random transfers.
    for (int t = 0; t < 8; t++) begin
      n  = $urandom_range(40, 1);
      ab = ($urandom_range(3) == 0) ? $urandom_range(n, 1) : -1;
      preload(n, 1'b0, '0);
      run_xfer(n, $urandom_range(90, 30), 0, 1, ab, dc);
    end

    // Reset mid-transfer with two words in flight.
    preload(10, 1'b0, '0);
    start = 1'b1; len = 8'd10; out_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 20 && !(dl_v[0] && dl_v[RD_LAT-1]); c++) begin
      cycle_check();
      tick();
    end
    chk("two_in_flight", 32'(dl_v[0] && dl_v[RD_LAT-1]), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("mid_rst_rinc", 32'(rinc), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_data", 32'(out_data), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_words_out", 32'(words_out), 32'd0);
    for (int c = 0; c < 6; c++) begin
      cycle_check();
      tick();
    end
    preload(5, 1'b1, WIDTH'(32'h200));
    run_xfer(5, 100, 0, 0, -1, dc);
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      chk("post_rst_order", 32'(got_q[i]), 32'h200 + 32'(i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fifo_drain_ctrl.md
FIFO_DRAIN_CTRL -- requirements
Module: fifo_drain_ctrl

Interface
REQ-001 Parameter WIDTH, default 32: data word width; matches the async FIFO read port.
REQ-002 Parameter RD_LAT, default 2: cycles from the pop edge to the edge where rdata is sampled (SRAM read plus FIFO output register).
REQ-003 Parameter BUF_DEPTH, default 4: local output buffer entries, power of two.
REQ-004 clk  input  1  the single clock, the FIFO read-side clock (rclk domain).
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  request a transfer, sampled only in IDLE.
REQ-007 len  input  8  number of words for the transfer, sampled with start.
REQ-008 abort  input  1  stop issuing further pops.
REQ-009 rinc  output  1  pop request to the FIFO read port.
REQ-010 rempty  input  1  FIFO empty flag, registered in the clk domain.
REQ-011 rdata  input  WIDTH  FIFO read data, valid RD_LAT cycles after an accepted pop.
REQ-012 out_valid  output  1  out_data holds a word.
REQ-013 out_ready  input  1  downstream accepts the word.
REQ-014 out_data  output  WIDTH  head word of the buffer.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse at transfer end.
REQ-017 words_out  output  8  words delivered downstream in the current or last transfer.

Function
REQ-018 The FSM SHALL have the states IDLE, RUN, FLUSH and DONE.
REQ-019 IDLE -> RUN on start with len!=0; IDLE -> DONE on start with len==0; latch len; clear the issued count and words_out.
REQ-020 RUN -> FLUSH when issued==len or abort; FLUSH -> DONE when in-flight==0 and buffer empty; DONE -> IDLE unconditionally.
REQ-021 rinc = (state==RUN) & (issued<len) & ~abort & (inflight+buf_cnt < BUF_DEPTH); combinational from registers and abort only.
REQ-022 A pop is accepted only when rinc & ~rempty; only accepted pops increment issued and enter the RD_LAT-deep in-flight shift register.
REQ-023 When an accepted pop reaches the end of the in-flight shift register, rdata SHALL be written into the buffer on that edge.
REQ-024 The credit rule guarantees the buffer never overflows; rdata that arrives is never dropped, including after abort.
REQ-025 out_valid = (buf_cnt!=0); out_data = head entry; a pop happens on out_valid & out_ready; words_out increments on each pop and does not wrap (len<=255).
REQ-026 A simultaneous buffer push and pop leaves buf_cnt unchanged; read and write pointers wrap modulo BUF_DEPTH.
REQ-027 rempty high while rinc is high stalls the transfer; issued, the FSM and in-flight state are unchanged.
REQ-028 done SHALL be high for exactly the cycle the FSM is in DONE; busy is low in that cycle only if DONE is not counted as busy — busy SHALL be high in DONE.
REQ-029 start while busy is ignored; abort outside RUN is ignored.

Reset
REQ-030 On a clk edge with rst_n low, the block SHALL enter IDLE and clear issued, in-flight, buf_cnt, the pointers and words_out.
REQ-031 Reset values: rinc=0, out_valid=0, out_data=0, busy=0, done=0, words_out=0.
REQ-032 Reset mid-transfer discards buffered and in-flight words; the FIFO is reset by the same rst_n.

Structure
REQ-033 WIDTH, RD_LAT and BUF_DEPTH defaults and the FSM state encoding (2-bit: IDLE=0, RUN=1, FLUSH=2, DONE=3) SHALL live in a shared package.
REQ-034 The output buffer SHALL be one sub-module, drain_obuf (BUF_DEPTH x WIDTH register file with push/pop/count); the FSM, credit logic and in-flight pipe sit in the top.

Verification
REQ-035 FIFO preloaded with 0x100..0x109, len=10, out_ready=1 -> out_data 0x100..0x109 in order, words_out=10, one done pulse, busy falls the cycle after done.
REQ-036 len=10 with out_ready=0 for 20 cycles -> rinc stops after 4 accepted pops, buf_cnt=4, no data loss once out_ready=1.
REQ-037 rempty toggled every 3 cycles during len=6 -> no pop counted while rempty=1, exactly 6 words delivered.
REQ-038 abort asserted after 3 accepted pops of len=20 -> rinc low from the abort cycle, 3 words delivered, then done.
REQ-039 start with len=0 -> done on the next cycle, rinc never high, words_out=0.
REQ-040 rst_n low for one edge mid-transfer with 2 words in flight -> all outputs at reset values next cycle, and no stale word appears afterwards.
